mio_counter: RTL and testbench

//   Three-channel 32-bit down-counter peripheral on the MIO bus, counter port.
//   It accepts the bus's write strobe and write data, and returns the selected register on counter_out.
//   It drives counter0_out/1/2 back to the bus, which feeds them to the CPU.

---
 rtl/mio_counter.sv | 73 +++++++
 tb/tb_mio_counter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mio_counter.sv
// mio_counter: three-channel 32-bit down-counter on the MIO bus.
// Each channel can run as a one-shot, a periodic pulse or a square wave, paced by a shared prescaler.
module mio_counter #(
   parameter int DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        counter_we,
   input  logic [1:0]  counter_sel,
   input  logic [31:0] Peripheral_in,
   output logic [31:0] counter_out,
   output logic        counter0_out,
   output logic        counter1_out,
   output logic        counter2_out
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;
   st_t         st [3];
   logic [31:0] count [3];
   logic [31:0] reload [3];
   logic [8:0]  ctrl;
   logic [2:0]  out;
   logic [31:0] pre;
   logic        tick;
   assign tick = pre == 32'(DIV - 1);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre  <= '0;
         ctrl <= '0;
         out  <= '0;
         for (int i = 0; i < 3; i++) begin
            count[i]  <= '0;
            reload[i] <= '0;
            st[i]     <= IDLE;
         end
      end else begin
         pre <= tick ? '0 : pre + 32'd1;
         if (counter_we && counter_sel == 2'd3) ctrl <= Peripheral_in[8:0];
         for (int i = 0; i < 3; i++) begin
            // periodic output is a single-cycle pulse; anything but a terminal tick drops it
            if (ctrl[3*i +: 2] == 2'b01) out[i] <= 1'b0;
            if (counter_we && counter_sel == 2'(i)) begin
               reload[i] <= Peripheral_in;
               count[i]  <= Peripheral_in;
               out[i]    <= 1'b0;
               st[i]     <= RUN;
            end else if (st[i] == RUN && tick && ctrl[3*i+2]) begin
               if (ctrl[3*i +: 2] == 2'b00) begin
                  if (count[i] > 32'd1) count[i] <= count[i] - 32'd1;
                  else begin
                     count[i] <= '0;
                     out[i]   <= 1'b1;
                     st[i]    <= DONE;
                  end
               end else if (ctrl[3*i +: 2] != 2'b11 && reload[i] != '0) begin
                  if (count[i] > 32'd1) count[i] <= count[i] - 32'd1;
                  else begin
                     count[i] <= reload[i];
                     out[i]   <= ctrl[3*i+1] ? ~out[i] : 1'b1;
                  end
               end
            end
            if (counter_we && counter_sel == 2'd3 && Peripheral_in[3*i +: 2] != ctrl[3*i +: 2])
               out[i] <= 1'b0;
         end
      end
   end
   assign counter_out = counter_sel == 2'd0 ? count[0] :
                        counter_sel == 2'd1 ? count[1] :
                        counter_sel == 2'd2 ? count[2] : {23'b0, ctrl};
   assign counter0_out = out[0];
   assign counter1_out = out[1];
   assign counter2_out = out[2];
endmodule

// File: tb/tb_mio_counter.sv
// tb_mio_counter: directed checks of mio_counter with DIV=1, plus a DIV=2 copy for prescaled square waves.
module tb_mio_counter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic [31:0] din = '0;
   logic [31:0] dout, v_dout;
   logic        o0, o1, o2, v0, v1, v2;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mio_counter #(.DIV(1)) u (
      .clk(clk), .rst(rst), .counter_we(we), .counter_sel(sel), .Peripheral_in(din),
      .counter_out(dout), .counter0_out(o0), .counter1_out(o1), .counter2_out(o2));

   mio_counter #(.DIV(2)) v (
      .clk(clk), .rst(rst), .counter_we(we), .counter_sel(sel), .Peripheral_in(din),
      .counter_out(v_dout), .counter0_out(v0), .counter1_out(v1), .counter2_out(v2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] s, input logic [31:0] d);
      we = 1'b1;
      sel = s;
      din = d;
      @(posedge clk);
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] s, input logic [31:0] exp, input string tag);
      sel = s;
      #1;
      chk(tag, dout, exp);
   endtask

   initial begin
      int t1, t2;
      logic vp;
      // reset at power-up
      #2 rst = 1'b0;
      #1;
      chk("reset outs", {29'b0, o0, o1, o2}, 32'd0);
      rd(2'd3, 32'd0, "reset ctrl");
      rd(2'd0, 32'd0, "reset count0");
      @(negedge clk);
      rst = 1'b1;
      // one-shot ch0 = 5
      wr(2'd3, 32'h004);
      rd(2'd3, 32'h004, "ctrl readback");
      wr(2'd0, 32'd5);
      rd(2'd0, 32'd5, "oneshot loaded");
      repeat (4) begin
         @(negedge clk);
         chk("oneshot low", {31'b0, o0}, 32'd0);
      end
      rd(2'd0, 32'd1, "oneshot count1");
      @(negedge clk);
      chk("oneshot fire", {31'b0, o0}, 32'd1);
      rd(2'd0, 32'd0, "oneshot count0");
      repeat (3) @(negedge clk);
      chk("oneshot held", {31'b0, o0}, 32'd1);
      // periodic ch1 = 3
      wr(2'd3, 32'h028);
      chk("ch0 held en off", {31'b0, o0}, 32'd1);
      wr(2'd1, 32'd3);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk($sformatf("periodic e%0d", k), {31'b0, o1}, {31'b0, k % 3 == 0});
      end
      // collision: reload ch1 on its terminal edge
      repeat (2) @(negedge clk);
      rd(2'd1, 32'd1, "pre-collision count");
      wr(2'd1, 32'd9);
      chk("collision no pulse", {31'b0, o1}, 32'd0);
      rd(2'd1, 32'd9, "collision count");
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         chk($sformatf("post-collision e%0d", k), {31'b0, o1}, {31'b0, k == 9});
      end
      // square ch2 = 4, also on the DIV=2 instance
      wr(2'd3, 32'h180);
      chk("mode change clears ch1", {31'b0, o1}, 32'd0);
      wr(2'd2, 32'd4);
      t1 = -1;
      t2 = -1;
      vp = v2;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         chk($sformatf("square e%0d", k), {31'b0, o2}, {31'b0, (k / 4) % 2 == 1});
         if (v2 !== vp) begin
            if (t1 < 0) t1 = k;
            else if (t2 < 0) t2 = k;
         end
         vp = v2;
      end
      chk("div2 toggle seen", {31'b0, t2 > 0}, 32'd1);
      chk("div2 half period", 32'(t2 - t1), 32'd8);
      // enable freeze and resume on ch0
      wr(2'd3, 32'h184);
      wr(2'd0, 32'd10);
      repeat (2) @(negedge clk);
      rd(2'd0, 32'd8, "enable count8");
      wr(2'd3, 32'h180);
      rd(2'd0, 32'd7, "enable count7");
      repeat (10) @(negedge clk);
      rd(2'd0, 32'd7, "frozen count");
      wr(2'd3, 32'h184);
      rd(2'd0, 32'd7, "resume edge");
      @(negedge clk);
      rd(2'd0, 32'd6, "resumed count6");
      // reset mid-run
      rst = 1'b0;
      #1;
      chk("midrun reset outs", {29'b0, o0, o1, o2}, 32'd0);
      rd(2'd0, 32'd0, "midrun count0");
      rd(2'd2, 32'd0, "midrun count2");
      rd(2'd3, 32'd0, "midrun ctrl");
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      rd(2'd2, 32'd0, "idle after reset");
      chk("idle outs", {29'b0, o0, o1, o2}, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
